regfile_sb: RTL and testbench

Parametrised multi-port register file with a per-register pending-write scoreboard. It is the next generation of the CPU's `registers` block. It adds:
- configurable width, depth and read-port count;
- two write ports: ALU writeback and load writeback;
- same-cycle write-to-read bypass;
- an optional hardwired zero register;
- busy tracking for multi-cycle loads, so the decode stage can stall on RAW hazards.

It sits between decode (read/scoreboard ports) and the writeback stage.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_bypass.sv | 54 +++++
 rtl/regfile_sb.sv | 101 ++++++++++
 tb/tb_regfile_sb.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, helpers and types for the register file
//
// Purpose: build-time defaults for regfile_sb, the address-width helper and
// the write-port record shared with the writeback stage.
package regfile_pkg;

  localparam int REG_WIDTH_DEF = 16;

  localparam int NUM_REGS_DEF = 8;

  localparam int NUM_RD_PORTS_DEF = 3;

  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

  // Writeback port record at the default geometry.
  typedef struct packed {
    logic                            en;
    logic [$clog2(NUM_REGS_DEF)-1:0] addr;
    logic [REG_WIDTH_DEF-1:0]        data;
  } wr_port_t;

endpackage

// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - one read port: zero / wb / wa / stored priority mux and busy bypass
//
// Purpose: resolves one read port against the writes in flight this cycle.
// Ports:
//   addr                        read address of this port
//   wa_en, wa_addr, wa_data     ALU writeback in flight
//   wb_en, wb_addr, wb_data     load writeback in flight
//   stored_data, stored_busy    storage and scoreboard contents at addr
//   data, busy                  bypassed read data and busy bit
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int AW        = 3,
  parameter int REG_WIDTH = 16,
  parameter int ZERO_REG  = 1
) (
  input  logic [AW-1:0]        addr,
  input  logic                 wa_en,
  input  logic [AW-1:0]        wa_addr,
  input  logic [REG_WIDTH-1:0] wa_data,
  input  logic                 wb_en,
  input  logic [AW-1:0]        wb_addr,
  input  logic [REG_WIDTH-1:0] wb_data,
  input  logic [REG_WIDTH-1:0] stored_data,
  input  logic                 stored_busy,
  output logic [REG_WIDTH-1:0] data,
  output logic                 busy
);

  logic zero_hit;
  logic wb_hit;
  logic wa_hit;

  assign zero_hit = (ZERO_REG != 0) && (addr == '0);
  assign wb_hit   = wb_en && (wb_addr == addr);
  assign wa_hit   = wa_en && (wa_addr == addr);

  always_comb begin
    data = stored_data;
    busy = stored_busy;
    if (zero_hit) begin
      data = '0;
      busy = 1'b0;
    end else if (wb_hit) begin
      // The load result is forwarded now, so decode need not stall on it.
      data = wb_data;
      busy = 1'b0;
    end else if (wa_hit) begin
      // ALU results never touch the scoreboard, so busy stays as stored.
      data = wa_data;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with pending-load scoreboard
//
// Purpose: register storage with two write ports (ALU wa, load wb), bypassed
// combinational read ports and a per-register busy bit for in-flight loads.
// Ports:
//   CLK, RST                          clock; asynchronous active-low reset
//   rd_addr, rd_data, rd_busy         packed read ports (port i at slice i)
//   wa_en, wa_addr, wa_data           ALU writeback
//   wb_en, wb_addr, wb_data           load writeback, clears busy
//   sb_set_en, sb_set_addr            marks a register pending
//   wr_conflict                       wa and wb hit the same register last cycle
//   busy_any                          OR of all busy bits after the last edge
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int REG_WIDTH    = REG_WIDTH_DEF,
  parameter int NUM_REGS     = NUM_REGS_DEF,
  parameter int NUM_RD_PORTS = NUM_RD_PORTS_DEF,
  parameter int ZERO_REG     = 1,
  localparam int AW          = addr_w(NUM_REGS)
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [NUM_RD_PORTS*AW-1:0]        rd_addr,
  output logic [NUM_RD_PORTS*REG_WIDTH-1:0] rd_data,
  output logic [NUM_RD_PORTS-1:0]           rd_busy,
  input  logic                              wa_en,
  input  logic [AW-1:0]                     wa_addr,
  input  logic [REG_WIDTH-1:0]              wa_data,
  input  logic                              wb_en,
  input  logic [AW-1:0]                     wb_addr,
  input  logic [REG_WIDTH-1:0]              wb_data,
  input  logic                              sb_set_en,
  input  logic [AW-1:0]                     sb_set_addr,
  output logic                              wr_conflict,
  output logic                              busy_any
);

  logic [REG_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]  busy;
  logic [NUM_REGS-1:0]  busy_nxt;
  logic                 wa_zero;
  logic                 wb_zero;
  logic                 same_addr;
  logic                 wa_write;
  logic                 wb_write;

  assign wa_zero   = (ZERO_REG != 0) && (wa_addr == '0);
  assign wb_zero   = (ZERO_REG != 0) && (wb_addr == '0);
  assign same_addr = wa_en && wb_en && (wa_addr == wb_addr);
  // On a same-address collision the load result wins and the ALU write is dropped.
  assign wa_write  = wa_en && !same_addr && !wa_zero;
  assign wb_write  = wb_en && !wb_zero;

  // Set is applied after clear so a load issued behind a completing one stays pending.
  always_comb begin
    busy_nxt = busy;
    if (wb_en) busy_nxt[wb_addr] = 1'b0;
    if (sb_set_en) busy_nxt[sb_set_addr] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy        <= '0;
      wr_conflict <= 1'b0;
      busy_any    <= 1'b0;
    end else begin
      if (wa_write) regs[wa_addr] <= wa_data;
      if (wb_write) regs[wb_addr] <= wb_data;
      busy        <= busy_nxt;
      wr_conflict <= same_addr && !wa_zero;
      busy_any    <= |busy_nxt;
    end
  end

  for (genvar g = 0; g < NUM_RD_PORTS; g++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rd_addr[g*AW +: AW];

    regfile_bypass #(
      .AW       (AW),
      .REG_WIDTH(REG_WIDTH),
      .ZERO_REG (ZERO_REG)
    ) u_bypass (
      .addr       (addr),
      .wa_en      (wa_en),
      .wa_addr    (wa_addr),
      .wa_data    (wa_data),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .stored_data(regs[addr]),
      .stored_busy(busy[addr]),
      .data       (rd_data[g*REG_WIDTH +: REG_WIDTH]),
      .busy       (rd_busy[g])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb (ZERO_REG=1 and ZERO_REG=0)
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int P  = 3;
  localparam int AW = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [P*AW-1:0] rd_addr = '0;
  logic          wa_en = 1'b0, wb_en = 1'b0, sb_set_en = 1'b0;
  logic [AW-1:0] wa_addr = '0, wb_addr = '0, sb_set_addr = '0;
  logic [W-1:0]  wa_data = '0, wb_data = '0;

  logic [P*W-1:0] rd_data_z0, rd_data_z1;
  logic [P-1:0]   rd_busy_z0, rd_busy_z1;
  logic           conf_z0, conf_z1, ba_z0, ba_z1;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  regfile_sb #(.REG_WIDTH(W), .NUM_REGS(N), .NUM_RD_PORTS(P), .ZERO_REG(0)) dut_z0 (
    .CLK(CLK), .RST(RST), .rd_addr(rd_addr), .rd_data(rd_data_z0), .rd_busy(rd_busy_z0),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .wr_conflict(conf_z0), .busy_any(ba_z0));

  regfile_sb #(.REG_WIDTH(W), .NUM_REGS(N), .NUM_RD_PORTS(P), .ZERO_REG(1)) dut_z1 (
    .CLK(CLK), .RST(RST), .rd_addr(rd_addr), .rd_data(rd_data_z1), .rd_busy(rd_busy_z1),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .wr_conflict(conf_z1), .busy_any(ba_z1));

  // Reference model: index 0 = ZERO_REG=0 instance, index 1 = ZERO_REG=1 instance.
  logic [W-1:0] mreg  [2][N];
  logic         mbusy [2][N];
  logic         mconf [2];
  logic         mba   [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < N; i++) begin
        mreg[z][i]  = '0;
        mbusy[z][i] = 1'b0;
      end
      mconf[z] = 1'b0;
      mba[z]   = 1'b0;
    end
  endtask

  // Architectural effect of one clock edge: ALU write then load write on top
  // (load wins a collision), clear then set of busy, register 0 pinned if zeroed.
  task automatic model_edge();
    for (int z = 0; z < 2; z++) begin
      mconf[z] = wa_en && wb_en && (wa_addr == wb_addr) && !(z == 1 && wa_addr == 0);
      if (wa_en) mreg[z][wa_addr] = wa_data;
      if (wb_en) mreg[z][wb_addr] = wb_data;
      if (wb_en) mbusy[z][wb_addr] = 1'b0;
      if (sb_set_en) mbusy[z][sb_set_addr] = 1'b1;
      if (z == 1) begin
        mreg[z][0]  = '0;
        mbusy[z][0] = 1'b0;
      end
      mba[z] = 1'b0;
      for (int i = 0; i < N; i++) mba[z] = mba[z] | mbusy[z][i];
    end
  endtask

  function automatic logic [W-1:0] exp_data(input int z, input logic [AW-1:0] a);
    if (z == 1 && a == 0) return '0;
    if (wb_en && wb_addr == a) return wb_data;
    if (wa_en && wa_addr == a) return wa_data;
    return mreg[z][a];
  endfunction

  function automatic logic exp_busy(input int z, input logic [AW-1:0] a);
    if (z == 1 && a == 0) return 1'b0;
    if (wb_en && wb_addr == a) return 1'b0;
    return mbusy[z][a];
  endfunction

  task automatic check_comb();
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    logic          b;
    for (int z = 0; z < 2; z++) begin
      for (int p = 0; p < P; p++) begin
        a = rd_addr[p*AW +: AW];
        d = (z == 1) ? rd_data_z1[p*W +: W] : rd_data_z0[p*W +: W];
        b = (z == 1) ? rd_busy_z1[p] : rd_busy_z0[p];
        check($sformatf("rd_data z%0d p%0d r%0d", z, p, a), {16'h0, d}, {16'h0, exp_data(z, a)});
        check($sformatf("rd_busy z%0d p%0d r%0d", z, p, a), {31'h0, b}, {31'h0, exp_busy(z, a)});
      end
    end
  endtask

  task automatic check_regs();
    check("wr_conflict z0", {31'h0, conf_z0}, {31'h0, mconf[0]});
    check("wr_conflict z1", {31'h0, conf_z1}, {31'h0, mconf[1]});
    check("busy_any z0", {31'h0, ba_z0}, {31'h0, mba[0]});
    check("busy_any z1", {31'h0, ba_z1}, {31'h0, mba[1]});
  endtask

  // Inputs are set just after a falling edge; one call spans one rising edge.
  task automatic cycle();
    #1 check_comb();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_regs();
  endtask

  task automatic idle();
    wa_en = 1'b0; wb_en = 1'b0; sb_set_en = 1'b0;
  endtask

  typedef struct {
    logic          wa_en;
    logic [AW-1:0] wa_addr;
    logic [W-1:0]  wa_data;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [W-1:0]  wb_data;
    logic          sb_en;
    logic [AW-1:0] sb_addr;
    logic [AW-1:0] ra;
    logic [W-1:0]  e_data;   // port 0 data, ZERO_REG=1, before the edge
    logic          e_busy;   // port 0 busy, ZERO_REG=1, before the edge
    logic          e_conf;   // wr_conflict after the edge
    logic          e_ba;     // busy_any after the edge
  } vec_t;

  function automatic vec_t mk(input logic wae, input int waa, input int wad,
                              input logic wbe, input int wba, input int wbd,
                              input logic sbe, input int sba, input int ra,
                              input int ed, input logic eb, input logic ec, input logic eba);
    vec_t v;
    v.wa_en = wae; v.wa_addr = AW'(waa); v.wa_data = W'(wad);
    v.wb_en = wbe; v.wb_addr = AW'(wba); v.wb_data = W'(wbd);
    v.sb_en = sbe; v.sb_addr = AW'(sba); v.ra = AW'(ra);
    v.e_data = W'(ed); v.e_busy = eb; v.e_conf = ec; v.e_ba = eba;
    return v;
  endfunction

  vec_t tbl [14];

  initial begin
    tbl[0]  = mk(1, 2, 'h1234, 0, 0, 0,      0, 0, 2, 'h1234, 0, 0, 0); // wa bypass
    tbl[1]  = mk(0, 0, 0,      0, 0, 0,      0, 0, 2, 'h1234, 0, 0, 0); // stored after edge
    tbl[2]  = mk(1, 5, 'h1111, 1, 5, 'h2222, 0, 0, 5, 'h2222, 0, 1, 0); // wa/wb collision
    tbl[3]  = mk(0, 0, 0,      0, 0, 0,      0, 0, 5, 'h2222, 0, 0, 0); // conflict one cycle only
    tbl[4]  = mk(0, 0, 0,      0, 0, 0,      1, 4, 4, 0,      0, 0, 1); // set not yet visible
    tbl[5]  = mk(0, 0, 0,      0, 0, 0,      0, 0, 4, 0,      1, 0, 1); // busy visible
    tbl[6]  = mk(0, 0, 0,      1, 4, 'h00AA, 0, 0, 4, 'h00AA, 0, 0, 0); // wb bypass clears busy
    tbl[7]  = mk(0, 0, 0,      0, 0, 0,      0, 0, 4, 'h00AA, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0,      1, 6, 7,      1, 6, 6, 7,      0, 0, 1); // set/clear collision
    tbl[9]  = mk(0, 0, 0,      0, 0, 0,      0, 0, 6, 7,      1, 0, 1); // set won
    tbl[10] = mk(0, 0, 0,      1, 6, 9,      0, 0, 6, 9,      0, 0, 0);
    tbl[11] = mk(1, 0, 'hFFFF, 0, 0, 0,      1, 0, 0, 0,      0, 0, 0); // zero reg
    tbl[12] = mk(0, 0, 0,      0, 0, 0,      0, 0, 0, 0,      0, 0, 0);
    tbl[13] = mk(1, 0, 'h3333, 1, 0, 'h4444, 0, 0, 0, 0,      0, 0, 0); // no conflict on r0

    model_reset();
    idle();
    rd_addr = {3'd5, 3'd3, 3'd0};
    repeat (2) @(negedge CLK);
    check("reset busy_any", {31'h0, ba_z1}, 32'h0);
    check("reset wr_conflict", {31'h0, conf_z1}, 32'h0);
    check("reset rd r3", {16'h0, rd_data_z0[W +: W]}, 32'h0);
    RST = 1'b1;

    for (int i = 0; i < 14; i++) begin
      wa_en = tbl[i].wa_en; wa_addr = tbl[i].wa_addr; wa_data = tbl[i].wa_data;
      wb_en = tbl[i].wb_en; wb_addr = tbl[i].wb_addr; wb_data = tbl[i].wb_data;
      sb_set_en = tbl[i].sb_en; sb_set_addr = tbl[i].sb_addr;
      rd_addr = {3'd5, 3'd1, tbl[i].ra};
      #1;
      check($sformatf("vec%0d data", i), {16'h0, rd_data_z1[W-1:0]}, {16'h0, tbl[i].e_data});
      check($sformatf("vec%0d busy", i), {31'h0, rd_busy_z1[0]}, {31'h0, tbl[i].e_busy});
      cycle();
      check($sformatf("vec%0d conflict", i), {31'h0, conf_z1}, {31'h0, tbl[i].e_conf});
      check($sformatf("vec%0d busy_any", i), {31'h0, ba_z1}, {31'h0, tbl[i].e_ba});
      idle();
    end

    // Zero register only exists when ZERO_REG=1.
    wa_en = 1'b1; wa_addr = 3'd0; wa_data = 16'hFFFF;
    sb_set_en = 1'b1; sb_set_addr = 3'd0;
    rd_addr = {3'd0, 3'd0, 3'd0};
    cycle();
    idle();
    #1;
    check("zero z1 data", {16'h0, rd_data_z1[W-1:0]}, 32'h0);
    check("zero z1 busy", {31'h0, rd_busy_z1[0]}, 32'h0);
    check("nonzero z0 data", {16'h0, rd_data_z0[W-1:0]}, 32'hFFFF);
    check("nonzero z0 busy", {31'h0, rd_busy_z0[0]}, 32'h1);
    @(negedge CLK);

    // Asynchronous reset mid-load, observed before any clock edge.
    wa_en = 1'b1; wa_addr = 3'd3; wa_data = 16'hBEEF;
    sb_set_en = 1'b1; sb_set_addr = 3'd1;
    rd_addr = {3'd1, 3'd1, 3'd3};
    cycle();
    idle();
    #1;
    check("pre-reset r3", {16'h0, rd_data_z1[W-1:0]}, 32'hBEEF);
    check("pre-reset busy_any", {31'h0, ba_z1}, 32'h1);
    #2 RST = 1'b0;
    #1;
    check("async reset r3 z1", {16'h0, rd_data_z1[W-1:0]}, 32'h0);
    check("async reset r3 z0", {16'h0, rd_data_z0[W-1:0]}, 32'h0);
    check("async reset busy r1", {31'h0, rd_busy_z1[1]}, 32'h0);
    check("async reset busy_any z1", {31'h0, ba_z1}, 32'h0);
    check("async reset busy_any z0", {31'h0, ba_z0}, 32'h0);
    model_reset();
    @(negedge CLK);
    RST = 1'b1;

    for (int n = 0; n < 400; n++) begin
      wa_en = 1'($urandom_range(0, 1));
      wa_addr = AW'($urandom_range(0, N - 1));
      wa_data = W'($urandom);
      wb_en = 1'($urandom_range(0, 1));
      wb_addr = AW'($urandom_range(0, N - 1));
      wb_data = W'($urandom);
      sb_set_en = 1'($urandom_range(0, 1));
      sb_set_addr = AW'($urandom_range(0, N - 1));
      rd_addr = (P*AW)'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
